bram_stream_reader: RTL
=======================

Name: bram_stream_reader

Overview:
Read-side master for the 256-bit simple dual-port block RAM. On a start command it walks a contiguous address range on the RAM read port (1-cycle registered read latency). It returns each word on a valid/ready stream with full backpressure support. It sits between activation/weight storage and the compute datapath, as the counterpart to the write-port loader.

Parameters:
ADDR_WIDTH, 15, RAM address width; must match the RAM instance.
DATA_WIDTH, 256, RAM word / stream data width.
LEN_WIDTH, 16, width of the word-count field.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
start  input  1  command strobe; sampled only in IDLE.
base_addr  input  ADDR_WIDTH  first RAM address; sampled with start.
num_words  input  LEN_WIDTH  number of words to stream; sampled with start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse at command completion.
ram_addr_b  output  ADDR_WIDTH  RAM read address; drives the RAM read-address port.
ram_dout_b  input  DATA_WIDTH  RAM read data; valid one cycle after the address is presented.
m_valid  output  1  stream data valid.
m_ready  input  1  downstream accept.
m_data  output  DATA_WIDTH  stream data.
m_last  output  1  high with the final beat of a command.

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE; busy=0; done=0; m_valid=0; m_last=0.
  - m_data=0; ram_addr_b=0.
  - Buffer emptied; in-flight flag and counters cleared.
- Reset mid-command aborts the command; no done is produced.
- FSM states:
  - IDLE: start=1 latches base_addr/num_words. If num_words=0, go to DONE; otherwise go to RUN.
  - RUN: issues reads. When the last address is issued, go to DRAIN.
  - DRAIN: waits until the final beat is accepted (m_valid & m_ready & m_last), then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; returns to IDLE.
- start is ignored outside IDLE.
- Read issue: ram_addr_b comes from a registered address counter. rd_issue is internal.
- Data capture: the word for an issue in cycle N is on ram_dout_b in cycle N+1. It is written into a 2-entry output FIFO at the end of cycle N+1.
- Credit rule: issue in a cycle only if (occupancy + inflight − pop) < 2, where pop = m_valid & m_ready.
  - This guarantees no overflow under any m_ready pattern.
  - It gives sustained 1 beat/cycle when m_ready is held high.
- Latency: start high in cycle 0 → first address in cycle 1 → first m_valid in cycle 3.
- Address arithmetic: the counter increments modulo 2^ADDR_WIDTH; it wraps from all-ones to 0 silently.
- Word counter: LEN_WIDTH bits; remaining issues decrement per issue. m_last is tracked per beat: the beat whose index equals num_words−1.
- Stream rules:
  - m_data, m_last and m_valid are stable while m_valid=1 and m_ready=0.
  - The FIFO head drives m_data directly.
  - m_valid drops only after the final pop with an empty FIFO.
- Simultaneous capture and pop on the same cycle: occupancy is unchanged and ordering is preserved.
- done timing: done is high in the cycle after the final beat handshake. busy falls in that same cycle.
- num_words=0 case: busy=1 for one cycle (DONE has busy=0; IDLE→DONE takes 1 cycle), then done pulses. No m_valid and no RAM reads occur.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE/RUN/DRAIN/DONE, 2 bits);
  - the default ADDR_WIDTH/DATA_WIDTH constants shared with the RAM.
- One natural sub-module: stream_fifo2, a 2-entry register FIFO with push/pop/count outputs, reusable by the write-side loader.

Test Plan:
- Preload RAM[i]=i replicated over all bytes. start, base=0x0010, num=8, m_ready=1 → m_valid first in cycle 3; 8 consecutive beats with data 0x10..0x17; m_last on beat 8; done one cycle after; no gaps.
- Same command with m_ready toggling 1,0,0,1 pattern → identical data order; m_data held stable while stalled; RAM never read beyond 0x17; FIFO never overflows (assertion on occupancy ≤ 2).
- base=0x7FFE, num=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001 in order; data matches; m_last on the 4th beat.
- num=0 → no m_valid, no addresses issued; done pulses once within 2 cycles of start.
- start re-asserted while busy with base=0x0100 → ignored; stream continues from the original range; done pulses once.
- rst_n driven low mid-stream after 3 beats → all outputs at reset values immediately (async). After release, a new command num=2 streams correctly with m_last on the 2nd beat.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: state encoding and RAM geometry shared by the reader and the write-side loader.
package bram_stream_reader_pkg;
  localparam int RAM_ADDR_WIDTH = 15;
  localparam int RAM_DATA_WIDTH = 256;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/bram_stream_reader_stream_fifo2.sv
// stream_fifo2: 2-entry register FIFO; head word drives o_data directly.
module stream_fifo2 #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_count;
  logic         w_push, w_pop;
  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
  assign o_data  = r_mem[r_rp];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a RAM address range on the read port and streams the words out on valid/ready.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_issue_left, r_beat_left;
  logic                  r_inflight, r_busy, r_done;
  logic [1:0]            w_count;
  logic                  w_pop, w_issue;
  assign m_valid    = w_count != 2'd0;
  assign w_pop      = m_valid && m_ready;
  assign m_last     = m_valid && (r_beat_left == LEN_WIDTH'(1));
  assign ram_addr_b = r_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  // Credit: a word already in flight will land next cycle, so count it against the 2 FIFO slots.
  assign w_issue = (r_state == S_RUN) &&
                   (({1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
  stream_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (ram_dout_b),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_count (w_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_beat_left  <= '0;
      r_inflight   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr       <= r_addr + ADDR_WIDTH'(1);
        r_issue_left <= r_issue_left - LEN_WIDTH'(1);
      end
      if (w_pop) r_beat_left <= r_beat_left - LEN_WIDTH'(1);
      case (r_state)
        S_IDLE: if (start) begin
          r_addr       <= (num_words == '0) ? r_addr : base_addr;
          r_issue_left <= num_words;
          r_beat_left  <= num_words;
          r_busy       <= 1'b1;
          r_state      <= (num_words == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (w_issue && r_issue_left == LEN_WIDTH'(1)) r_state <= S_DRAIN;
        S_DRAIN: if (w_pop && m_last) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        // Entered from IDLE on an empty command, DONE spends one busy cycle before pulsing done.
        S_DONE: if (r_done) begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
